aes_result_ser: RTL

//  Downstream of the AES decrypt core. Captures each 128-bit result block on the

---
 rtl/aes_result_ser_pkg.sv | 23 ++
 rtl/aes_blk_shift.sv | 53 +++++
 rtl/aes_result_ser.sv | 81 ++++++++
 3 files changed

// File: rtl/aes_result_ser_pkg.sv
// Shared definitions for the AES result path. The input assembler relies on the
// same byte-order convention: byte0 = bits [7:0], carried first on the byte bus.
package aes_result_ser_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_NBYTES = 16;

  // Buffer occupancy (act_full, pend_full); (0,1) cannot occur.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SEND      = 2'b10,
    ST_SEND_PEND = 2'b11
  } ser_st_e;

  function automatic ser_st_e ser_state(input logic act_full, input logic pend_full);
    ser_st_e st;
    st = ST_IDLE;
    if (act_full && pend_full) st = ST_SEND_PEND;
    else if (act_full)         st = ST_SEND;
    return st;
  endfunction

endpackage

// File: rtl/aes_blk_shift.sv
// Block shift register: loads a whole block, presents its low byte and shifts
// right one byte per accepted transfer. Flags the final byte of the block.
module aes_blk_shift
  import aes_result_ser_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   load_data,
  input  logic                  shift,
  output logic [7:0]            byte_out,
  output logic                  full,
  output logic                  last
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [8*NBYTES-1:0] data_q;
  logic [IDX_W-1:0]    idx_q;
  logic                full_q;

  assign byte_out = data_q[7:0];
  assign full     = full_q;
  assign last     = full_q && (idx_q == IDX_W'(NBYTES - 1));

  // Load / shift sequencing; a load on the last-byte shift chains blocks without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (shift && last) begin
      idx_q <= '0;
      if (load) begin
        data_q <= load_data;
        full_q <= 1'b1;
      end else begin
        data_q <= '0;
        full_q <= 1'b0;
      end
    end else if (shift) begin
      data_q <= data_q >> 8;
      idx_q  <= idx_q + 1'b1;
    end else if (load) begin
      data_q <= load_data;
      idx_q  <= '0;
      full_q <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_result_ser.sv
// AES result serializer: captures decrypted blocks and streams them out as bytes
// over valid/ready, with one active block and one pending block.
module aes_result_ser
  import aes_result_ser_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                o_valid,
  input  logic [8*NBYTES-1:0] aes_out,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                blk_done,
  output logic [CNT_W-1:0]    blk_cnt,
  output logic                ovf
);

  logic                act_full, act_last, act_load;
  logic                hs, last_hs;
  logic [8*NBYTES-1:0] act_data;
  logic [8*NBYTES-1:0] pend_reg;
  logic                pend_full;
  ser_st_e             st;

  assign st       = ser_state(act_full, pend_full);
  assign tx_valid = act_full;
  assign hs       = act_full && tx_ready;
  assign last_hs  = hs && act_last;
  assign busy     = act_full | pend_full;

  // Active buffer refills from pend first (older block), otherwise straight from the core.
  assign act_load = (o_valid && (st == ST_IDLE)) || (last_hs && (pend_full || o_valid));
  assign act_data = pend_full ? pend_reg : aes_out;

  aes_blk_shift #(.NBYTES(NBYTES)) u_act (
    .clk       (clk),
    .rst       (rst),
    .load      (act_load),
    .load_data (act_data),
    .shift     (hs),
    .byte_out  (tx_data),
    .full      (act_full),
    .last      (act_last)
  );

  // Pending buffer, overflow flag and block completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= '0;
      pend_full <= 1'b0;
      ovf       <= 1'b0;
      blk_done  <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      blk_done <= last_hs;
      if (last_hs) blk_cnt <= blk_cnt + 1'b1;
      case (st)
        ST_SEND: begin
          if (o_valid && !last_hs) begin
            pend_reg  <= aes_out;
            pend_full <= 1'b1;
          end
        end
        ST_SEND_PEND: begin
          if (last_hs) begin
            if (o_valid) pend_reg <= aes_out;
            else         pend_full <= 1'b0;
          end else if (o_valid) begin
            ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
